// File: rtl/mips_pkg.sv
// mips_pkg
// Types and helpers shared by the pipeline control logic of the 5-stage
// MIPS core.
//   pc_sel_t   : PC source select encoding driven by the hazard controller
//   hz_state_t : hazard controller sequencing states
//   REG_ZERO   : architectural $zero, never a real hazard source
//   reg_match  : does the ID instruction read register x?
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_EXC = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        REDIRECT
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producer writing $zero never creates a dependency, since $zero reads as 0.
    function automatic logic reg_match(
        input logic [4:0] x,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return (x != REG_ZERO) && ((uses_rs && (rs == x)) || (uses_rt && (rt == x)));
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter
// Tracks how long the multi-cycle mult/div unit stays busy after an
// accepted start.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-high
//   start : accepted mult/div issue this cycle (loads MD_LATENCY)
//   busy  : unit busy (counter nonzero)
module md_busy_counter #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(MD_LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Detects
// load-use and branch-operand hazards, stalls on the busy mult/div unit,
// squashes the wrong-path fetch on taken branch/jump, and runs the
// exception drain-and-redirect sequence.
//   inputs  : ID operand/type info, EX/MEM destination info, exception
//   pc_en, pc_sel          : PC load enable and source select
//   ifid_en, ifid_flush    : IF/ID register enable / clear to NOP
//   idex_flush             : ID/EX clear to bubble
//   epc_we                 : capture EPC this cycle
//   md_busy                : mult/div unit busy
//   exc_active             : exception sequence in progress
// Outputs are combinational from the registered state and current inputs.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int EXC_DRAIN  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_branch,
    input  logic       id_br_taken,
    input  logic       id_jump,
    input  logic       id_uses_hilo,
    input  logic       id_md_start,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_mem_read,
    input  logic       exception,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       epc_we,
    output logic       md_busy,
    output logic       exc_active
);

    localparam int DW = (EXC_DRAIN > 1) ? $clog2(EXC_DRAIN) : 1;

    hz_state_t     state;
    logic [DW-1:0] drain_cnt;

    logic    ex_match;
    logic    mem_match;
    logic    load_use;
    logic    br_dep;
    logic    md_stall;
    logic    stall;
    logic    redirect_br;
    logic    md_accept;
    pc_sel_t sel;

    // Hazard detection
    assign ex_match  = reg_match(ex_rd,  id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign mem_match = reg_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);

    assign load_use = ex_mem_read && ex_match;
    // Branch compare happens in ID, so an operand still in EX (any write) or
    // a load still in MEM is not yet forwardable.
    assign br_dep   = (id_branch || id_jump) &&
                      ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    assign md_stall = md_busy && (id_uses_hilo || id_md_start);
    assign stall    = load_use || br_dep || md_stall;

    assign redirect_br = (id_branch && id_br_taken) || id_jump;

    // A mult/div issues only from an unstalled RUN cycle with no exception.
    assign md_accept = (state == RUN) && !exception && !stall && id_md_start;

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .clk   (clk),
        .rst   (rst),
        .start (md_accept),
        .busy  (md_busy)
    );

    // Exception sequencing FSM and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (exception) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(EXC_DRAIN - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= REDIRECT;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                REDIRECT: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    // Control outputs
    // NOTE: every output gets a default at the top of the block so no path
    // through the case leaves one unassigned, which would infer a latch.
    always_comb begin
        pc_en      = 1'b0;
        sel        = PC_SEQ;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        epc_we     = 1'b0;
        exc_active = 1'b0;

        if (!rst) begin
            case (state)
                RUN: begin
                    if (exception) begin
                        epc_we = 1'b1;
                    end else if (stall) begin
                        ifid_flush = 1'b0;
                    end else if (redirect_br) begin
                        pc_en      = 1'b1;
                        sel        = PC_BR;
                        ifid_en    = 1'b1;
                        idex_flush = 1'b0;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                    end
                end
                DRAIN: begin
                    exc_active = 1'b1;
                end
                REDIRECT: begin
                    pc_en      = 1'b1;
                    sel        = PC_EXC;
                    exc_active = 1'b1;
                end
                default: begin
                    exc_active = 1'b1;
                end
            endcase
        end
    end

    assign pc_sel = sel;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Output bundle order:
//   {pc_en, pc_sel[1:0], ifid_en, ifid_flush, idex_flush, epc_we, md_busy, exc_active}
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_branch;
    logic       id_br_taken;
    logic       id_jump;
    logic       id_uses_hilo;
    logic       id_md_start;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_mem_read;
    logic       exception;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       epc_we;
    logic       md_busy;
    logic       exc_active;

    int vectors     = 0;
    int miscompares = 0;

    // Expected bundles (md_busy bit is 1, exc_active bit is 0)
    localparam logic [8:0] V_RST   = 9'b0_00_0_1_1_0_0_0;
    localparam logic [8:0] V_RUN   = 9'b1_00_1_0_0_0_0_0;
    localparam logic [8:0] V_STALL = 9'b0_00_0_0_1_0_0_0;
    localparam logic [8:0] V_BR    = 9'b1_01_1_1_0_0_0_0;
    localparam logic [8:0] V_EXC   = 9'b0_00_0_1_1_1_0_0;
    localparam logic [8:0] V_MD    = 9'b0_00_0_0_0_0_1_0;
    // Bundles without ifid_en for the DRAIN/REDIRECT states
    localparam logic [7:0] X_DRAIN = 8'b0_00_1_1_0_0_1;
    localparam logic [7:0] X_REDIR = 8'b1_10_1_1_0_0_1;
    localparam logic [7:0] X_MD    = 8'b0_00_0_0_0_1_0;

    logic [8:0] outs;
    logic [7:0] outs_x;
    assign outs   = {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, epc_we, md_busy, exc_active};
    assign outs_x = {pc_en, pc_sel, ifid_flush, idex_flush, epc_we, md_busy, exc_active};

    hazard_ctrl #(
        .MD_LATENCY (32),
        .EXC_DRAIN  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .id_br_taken  (id_br_taken),
        .id_jump      (id_jump),
        .id_uses_hilo (id_uses_hilo),
        .id_md_start  (id_md_start),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_mem_read (mem_mem_read),
        .exception    (exception),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .epc_we       (epc_we),
        .md_busy      (md_busy),
        .exc_active   (exc_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_branch    = 1'b0;
        id_br_taken  = 1'b0;
        id_jump      = 1'b0;
        id_uses_hilo = 1'b0;
        id_md_start  = 1'b0;
        ex_rd        = 5'd0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        mem_rd       = 5'd0;
        mem_mem_read = 1'b0;
        exception    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (outs !== V_RST) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want %b", outs, V_RST);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b want %b", outs, V_RUN);
        end
    endtask

    task automatic test_load_use();
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5;
        #1;
        vectors++;
        if (outs !== V_STALL) begin
            miscompares++;
            $display("FAIL load_use_rs: got %b want %b", outs, V_STALL);
        end
        step();
        id_uses_rs = 1'b1; id_rs = 5'd5; ex_rd = 5'd5;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL load_use_cleared: got %b want %b", outs, V_RUN);
        end
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_uses_rt = 1'b1; id_rt = 5'd9; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        vectors++;
        if (outs !== V_STALL) begin
            miscompares++;
            $display("FAIL load_use_rt: got %b want %b", outs, V_STALL);
        end
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_uses_rt = 1'b0; id_rt = 5'd9;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL load_use_rt_unused: got %b want %b", outs, V_RUN);
        end
    endtask

    task automatic test_zero_guard();
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL zero_guard: got %b want %b", outs, V_RUN);
        end
    endtask

    task automatic test_branch_dep();
        step();
        id_branch = 1'b1; id_br_taken = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
        id_uses_rt = 1'b1; id_rt = 5'd7;
        #1;
        vectors++;
        if (outs !== V_STALL) begin
            miscompares++;
            $display("FAIL branch_dep_stall: got %b want %b", outs, V_STALL);
        end
        step();
        id_branch = 1'b1; id_br_taken = 1'b1; ex_rd = 5'd7; id_uses_rt = 1'b1; id_rt = 5'd7;
        #1;
        vectors++;
        if (outs !== V_BR) begin
            miscompares++;
            $display("FAIL branch_taken: got %b want %b", outs, V_BR);
        end
        step();
        id_jump = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd12; id_uses_rs = 1'b1; id_rs = 5'd12;
        #1;
        vectors++;
        if (outs !== V_STALL) begin
            miscompares++;
            $display("FAIL jump_mem_load_dep: got %b want %b", outs, V_STALL);
        end
        step();
        id_branch = 1'b1; id_br_taken = 1'b0;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL branch_not_taken: got %b want %b", outs, V_RUN);
        end
        step();
        ex_reg_write = 1'b1; ex_rd = 5'd7; id_uses_rs = 1'b1; id_rs = 5'd7;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL alu_dep_no_branch: got %b want %b", outs, V_RUN);
        end
        step();
        id_jump = 1'b1;
        #1;
        vectors++;
        if (outs !== V_BR) begin
            miscompares++;
            $display("FAIL jump_taken: got %b want %b", outs, V_BR);
        end
    endtask

    task automatic test_mult_div();
        logic [8:0] exp;
        step();
        id_md_start = 1'b1;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL md_start_issue: got %b want %b", outs, V_RUN);
        end
        for (int i = 1; i <= 33; i++) begin
            step();
            if (i == 2) id_md_start = 1'b1;
            if (i >= 5) id_uses_hilo = 1'b1;
            #1;
            if (i == 33)
                exp = V_RUN;
            else if (i == 2 || i >= 5)
                exp = V_STALL | V_MD;
            else
                exp = V_RUN | V_MD;
            vectors++;
            if (outs !== exp) begin
                miscompares++;
                $display("FAIL md_cycle_%0d: got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_exception();
        step();
        exception = 1'b1; id_branch = 1'b1; id_br_taken = 1'b1; id_md_start = 1'b1;
        #1;
        vectors++;
        if (outs !== V_EXC) begin
            miscompares++;
            $display("FAIL exc_entry: got %b want %b", outs, V_EXC);
        end
        step();
        exception = 1'b1; id_branch = 1'b1; id_br_taken = 1'b1;
        #1;
        vectors++;
        if (outs_x !== X_DRAIN) begin
            miscompares++;
            $display("FAIL exc_drain_1: got %b want %b", outs_x, X_DRAIN);
        end
        step();
        exception = 1'b1;
        #1;
        vectors++;
        if (outs_x !== X_DRAIN) begin
            miscompares++;
            $display("FAIL exc_drain_2: got %b want %b", outs_x, X_DRAIN);
        end
        step();
        #1;
        vectors++;
        if (outs_x !== X_REDIR) begin
            miscompares++;
            $display("FAIL exc_redirect: got %b want %b", outs_x, X_REDIR);
        end
        step();
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL exc_back_to_run: got %b want %b", outs, V_RUN);
        end
    endtask

    task automatic test_reset_mid_drain();
        step();
        id_md_start = 1'b1;
        step();
        exception = 1'b1;
        step();
        #1;
        vectors++;
        if (outs_x !== (X_DRAIN | X_MD)) begin
            miscompares++;
            $display("FAIL mid_drain_busy: got %b want %b", outs_x, X_DRAIN | X_MD);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (outs !== V_RST) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", outs, V_RST);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (outs !== V_RUN) begin
            miscompares++;
            $display("FAIL after_reset_run: got %b want %b", outs, V_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_guard();
        test_branch_dep();
        test_mult_div();
        test_exception();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). Detects load-use and branch-operand hazards, stalls on the multi-cycle multiply/divide unit, and squashes wrong-path fetches on taken branch/jump. Runs the exception drain-and-redirect sequence. Drives the PC enable, PC source select and per-stage pipeline-register enable/flush signals.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit stays busy after md_start (>=2)
EXC_DRAIN, 2, cycles PC is frozen after an exception so older instructions in EX/MEM/WB retire (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a conditional branch (compare done in ID)
id_br_taken  in  1  branch condition true (from equal)
id_jump  in  1  ID instruction is a jump
id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
id_md_start  in  1  ID instruction is mult/div
ex_rd  in  5  destination register in EX
ex_reg_write  in  1  EX instruction writes register file
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  5  destination register in MEM
mem_mem_read  in  1  MEM instruction is a load
exception  in  1  exception raised by ID/EX (level, sampled per cycle)
pc_en  out  1  PC register load enable
pc_sel  out  2  00 sequential, 01 branch/jump target, 10 exception vector (fixed)
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to bubble
epc_we  out  1  capture EPC this cycle
md_busy  out  1  mult/div unit busy
exc_active  out  1  FSM not in RUN

Behaviour:
- Match rule: r matches X iff X != 0 and ((id_uses_rs and id_rs==X) or (id_uses_rt and id_rt==X)).
- load_use = ex_mem_read and match(ex_rd).
- br_dep = (id_branch or id_jump) and ((ex_reg_write and match(ex_rd)) or (mem_mem_read and match(mem_rd))).
- md_stall = md_busy and (id_uses_hilo or id_md_start).
- stall = load_use or br_dep or md_stall.
- Outputs are combinational from registered state and current inputs. Only the FSM, drain counter and md counter are registered.
- FSM states: RUN, DRAIN, REDIRECT. Reset -> RUN, drain_cnt=0, md_cnt=0.
- While rst high: pc_en=0, pc_sel=00, ifid_en=0, ifid_flush=1, idex_flush=1, epc_we=0, md_busy=0, exc_active=0.
- RUN, exception=1 (highest priority): epc_we=1, pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1. Next state DRAIN, drain_cnt=EXC_DRAIN-1. Any coincident stall, branch or md_start is discarded.
- RUN, stall: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, pc_sel=00. Branch/jump is not acted on while stalled. md_start is not accepted.
- RUN, no stall, (id_branch and id_br_taken) or id_jump: pc_en=1, pc_sel=01, ifid_en=1, ifid_flush=1 (one-slot squash, no delay slot).
- RUN, otherwise: pc_en=1, pc_sel=00, ifid_en=1, flushes=0.
- DRAIN: pc_en=0, ifid_flush=1, idex_flush=1, exc_active=1. exception is ignored. When drain_cnt==0, next state is REDIRECT; else decrement.
- REDIRECT: one cycle; pc_en=1, pc_sel=10, ifid_flush=1, idex_flush=1, exc_active=1. Next state RUN.
- md counter: accepted md_start (RUN, no stall, no exception, id_md_start) loads md_cnt=MD_LATENCY. md_busy = (md_cnt!=0). Decrements every cycle while nonzero, including during DRAIN/REDIRECT. An exception does not cancel an in-flight op.
- Width: md_cnt is clog2(MD_LATENCY+1) bits; drain_cnt is clog2(EXC_DRAIN) bits (min 1). No wrap permitted.
- Async rst mid-sequence returns to RUN and clears both counters immediately.

Decomposition:
- mips_pkg: pc_sel_t enum (PC_SEQ=2'b00, PC_BR=2'b01, PC_EXC=2'b10), hz_state_t enum (RUN, DRAIN, REDIRECT), REG_ZERO=5'd0.
- Sub-module md_busy_counter (clk, rst, start, busy; parameter MD_LATENCY), instantiated once.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs=1, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1. Next cycle, with ex_mem_read=0 -> pc_en=1, no flush.
- $zero guard: same as load-use but ex_rd=0, id_rs=0 -> no stall, pc_en=1.
- Branch after ALU write: id_branch=1, id_br_taken=1, ex_reg_write=1, ex_rd=id_rt=7 -> 1 stall cycle with pc_sel=00. Next cycle, with the hazard cleared -> pc_sel=01, ifid_flush=1.
- Mult/div: md_start accepted at cycle 0 -> md_busy=1 for exactly 32 cycles. An mflo in ID at cycle 5 stalls until md_busy falls, then issues.
- Exception: exception=1 in RUN, with a taken branch the same cycle -> epc_we=1 that cycle only, pc_en=0 for 1+2 cycles, then REDIRECT with pc_sel=10, pc_en=1, then RUN. The branch is never taken. A second exception during DRAIN is ignored.
- Reset mid-DRAIN: assert rst asynchronously -> outputs go to reset values without a clock edge. After release, state is RUN and md_busy=0.
